// File: rtl/vector_store_arbiter_pkg.sv
// Shared definitions for the vector store arbiter: default widths and store port tags.
package vector_store_arbiter_pkg;

    localparam int unsigned DefValueWidth   = 16;
    localparam int unsigned DefAddressWidth = 10;

    typedef enum logic {
        PORT1 = 1'b0,
        PORT2 = 1'b1
    } port_tag_e;

endpackage

// File: rtl/vector_store_arbiter.sv
// Two-requester arbiter in front of a dual-read, single-write store with registered outputs.
// Writes always go through store port 1; reads take whichever port the cycle leaves free.
module vector_store_arbiter
    import vector_store_arbiter_pkg::*;
#(
    parameter int unsigned value_width   = DefValueWidth,
    parameter int unsigned address_width = DefAddressWidth
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req0_valid,
    input  logic                     req0_we,
    input  logic [address_width-1:0] req0_address,
    input  logic [value_width-1:0]   req0_write_value,
    output logic                     req0_ready,
    output logic                     rsp0_valid,
    output logic [value_width-1:0]   rsp0_read_val,

    input  logic                     req1_valid,
    input  logic                     req1_we,
    input  logic [address_width-1:0] req1_address,
    input  logic [value_width-1:0]   req1_write_value,
    output logic                     req1_ready,
    output logic                     rsp1_valid,
    output logic [value_width-1:0]   rsp1_read_val,

    output logic                     st_wr_en,
    output logic [address_width-1:0] st_address1,
    output logic [address_width-1:0] st_address2,
    output logic [value_width-1:0]   st_write_value,
    input  logic [value_width-1:0]   st_read_val1,
    input  logic [value_width-1:0]   st_read_val2
);

    logic      wr0, wr1, rd0, rd1;
    logic      contested;
    logic      grant_wr0, grant_wr1;
    logic      acc_rd0, acc_rd1;
    logic      rr_ptr_q, rr_ptr_d;
    logic      rsp0_valid_q, rsp1_valid_q;
    port_tag_e tag0_q, tag0_d;
    port_tag_e tag1_q, tag1_d;

    // Request decode and grant. Only a write/write collision can stall anyone.
    always_comb begin
        wr0       = req0_valid & req0_we;
        wr1       = req1_valid & req1_we;
        rd0       = req0_valid & ~req0_we;
        rd1       = req1_valid & ~req1_we;
        contested = wr0 & wr1;

        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!reset) begin
            req0_ready = !(contested && rr_ptr_q);
            req1_ready = !(contested && !rr_ptr_q);
        end

        grant_wr0 = wr0 & req0_ready;
        grant_wr1 = wr1 & req1_ready;
        acc_rd0   = rd0 & req0_ready;
        acc_rd1   = rd1 & req1_ready;

        rr_ptr_d = rr_ptr_q ^ (contested & (grant_wr0 | grant_wr1));
    end

    // Store port steering; unused ports are parked at zero.
    always_comb begin
        st_wr_en       = grant_wr0 | grant_wr1;
        st_address1    = '0;
        st_address2    = '0;
        st_write_value = '0;
        tag0_d         = PORT1;
        tag1_d         = PORT2;

        if (grant_wr0) begin
            st_address1    = req0_address;
            st_write_value = req0_write_value;
        end else if (grant_wr1) begin
            st_address1    = req1_address;
            st_write_value = req1_write_value;
        end else if (acc_rd0) begin
            st_address1 = req0_address;
        end

        if (acc_rd1) begin
            st_address2 = req1_address;
        end else if (acc_rd0 && grant_wr1) begin
            // req1 owns port 1 for its write, so req0's read moves to port 2.
            st_address2 = req0_address;
            tag0_d      = PORT2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q     <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            tag0_q       <= PORT1;
            tag1_q       <= PORT1;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            rsp0_valid_q <= acc_rd0;
            rsp1_valid_q <= acc_rd1;
            if (acc_rd0) begin
                tag0_q <= tag0_d;
            end
            if (acc_rd1) begin
                tag1_q <= tag1_d;
            end
        end
    end

    // Masking with reset drops a response whose read was accepted just before reset rose.
    assign rsp0_valid    = rsp0_valid_q & ~reset;
    assign rsp1_valid    = rsp1_valid_q & ~reset;
    assign rsp0_read_val = (tag0_q == PORT2) ? st_read_val2 : st_read_val1;
    assign rsp1_read_val = (tag1_q == PORT2) ? st_read_val2 : st_read_val1;

`ifndef SYNTHESIS
    a_single_write: assert property (@(posedge clk) !(grant_wr0 && grant_wr1));
    a_no_write_in_reset: assert property (@(posedge clk) reset |-> !st_wr_en);
`endif

endmodule

// File: tb/tb_vector_store_arbiter.sv
// Self-checking bench for vector_store_arbiter with a behavioural registered store model.
module tb_vector_store_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_we, req1_valid, req1_we;
    logic [9:0]  req0_address, req1_address;
    logic [15:0] req0_write_value, req1_write_value;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_read_val, rsp1_read_val;
    logic        st_wr_en;
    logic [9:0]  st_address1, st_address2;
    logic [15:0] st_write_value, st_read_val1, st_read_val2;

    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [15:0] pl_data;
    logic [15:0] mem [1024];

    logic [15:0] ref_mem [1024];
    logic [15:0] sb0 [$];
    logic [15:0] sb1 [$];
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic        v0;
        logic        we0;
        logic [9:0]  a0;
        logic [15:0] d0;
        logic        v1;
        logic        we1;
        logic [9:0]  a1;
        logic [15:0] d1;
        logic        rdy0;
        logic        rdy1;
        logic        wr_en;
    } vec_t;

    vec_t tbl [$];

    always #5 clk = ~clk;

    vector_store_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .req0_valid       (req0_valid),
        .req0_we          (req0_we),
        .req0_address     (req0_address),
        .req0_write_value (req0_write_value),
        .req0_ready       (req0_ready),
        .rsp0_valid       (rsp0_valid),
        .rsp0_read_val    (rsp0_read_val),
        .req1_valid       (req1_valid),
        .req1_we          (req1_we),
        .req1_address     (req1_address),
        .req1_write_value (req1_write_value),
        .req1_ready       (req1_ready),
        .rsp1_valid       (rsp1_valid),
        .rsp1_read_val    (rsp1_read_val),
        .st_wr_en         (st_wr_en),
        .st_address1      (st_address1),
        .st_address2      (st_address2),
        .st_write_value   (st_write_value),
        .st_read_val1     (st_read_val1),
        .st_read_val2     (st_read_val2)
    );

    // Store: one write port on port 1, two registered read ports returning pre-write data.
    always_ff @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (st_wr_en) begin
            mem[st_address1] <= st_write_value;
        end
        st_read_val1 <= mem[st_address1];
        st_read_val2 <= mem[st_address2];
    end

    function automatic vec_t mk(input logic v0, input logic we0, input logic [9:0] a0,
                                input logic [15:0] d0, input logic v1, input logic we1,
                                input logic [9:0] a1, input logic [15:0] d1,
                                input logic rdy0, input logic rdy1, input logic wr_en);
        vec_t v;
        v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
        v.rdy0 = rdy0; v.rdy1 = rdy1; v.wr_en = wr_en;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [step %0d]: got 0x%0h, required 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req0_valid       = v.v0;
        req0_we          = v.we0;
        req0_address     = v.a0;
        req0_write_value = v.d0;
        req1_valid       = v.v1;
        req1_we          = v.we1;
        req1_address     = v.a1;
        req1_write_value = v.d1;
    endtask

    task automatic chk_rsp(input int idx);
        if (sb0.size() > 0) begin
            check("rsp0_valid", idx, 32'(rsp0_valid), 32'd1);
            check("rsp0_read_val", idx, 32'(rsp0_read_val), 32'(sb0.pop_front()));
        end else begin
            check("rsp0_valid", idx, 32'(rsp0_valid), 32'd0);
        end
        if (sb1.size() > 0) begin
            check("rsp1_valid", idx, 32'(rsp1_valid), 32'd1);
            check("rsp1_read_val", idx, 32'(rsp1_read_val), 32'(sb1.pop_front()));
        end else begin
            check("rsp1_valid", idx, 32'(rsp1_valid), 32'd0);
        end
    endtask

    // One normal cycle: check last cycle's responses, this cycle's grants, then update model.
    task automatic apply(input vec_t v, input int idx);
        drive(v);
        @(negedge clk);
        chk_rsp(idx);
        if (v.v0) check("req0_ready", idx, 32'(req0_ready), 32'(v.rdy0));
        if (v.v1) check("req1_ready", idx, 32'(req1_ready), 32'(v.rdy1));
        check("st_wr_en", idx, 32'(st_wr_en), 32'(v.wr_en));
        if (v.v0 && !v.we0 && v.rdy0) sb0.push_back(ref_mem[v.a0]);
        if (v.v1 && !v.we1 && v.rdy1) sb1.push_back(ref_mem[v.a1]);
        if (v.v0 && v.we0 && v.rdy0) ref_mem[v.a0] = v.d0;
        if (v.v1 && v.we1 && v.rdy1) ref_mem[v.a1] = v.d1;
        @(posedge clk);
        #1;
    endtask

    // Reset cycle with both requesters pushing writes: nothing may be granted or answered.
    task automatic rst_cycle(input int idx);
        reset = 1'b1;
        drive(mk(1, 1, 10'h060, 16'hDEAD, 1, 1, 10'h061, 16'hBEEF, 0, 0, 0));
        sb0.delete();
        sb1.delete();
        @(negedge clk);
        check("rst req0_ready", idx, 32'(req0_ready), 32'd0);
        check("rst req1_ready", idx, 32'(req1_ready), 32'd0);
        check("rst st_wr_en", idx, 32'(st_wr_en), 32'd0);
        check("rst rsp0_valid", idx, 32'(rsp0_valid), 32'd0);
        check("rst rsp1_valid", idx, 32'(rsp1_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    vec_t idle;

    initial begin
        idle  = mk(0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 1, 1, 0);
        reset = 1'b1;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        drive(idle);
        @(posedge clk);
        #1;
        preload(10'h005, 16'hAAAA);
        preload(10'h3FF, 16'h5555);
        preload(10'h010, 16'h0000);
        preload(10'h002, 16'hBEEF);
        preload(10'h020, 16'h0000);
        preload(10'h021, 16'h7777);
        rst_cycle(0);
        reset = 1'b0;

        //            v0 we0 a0       d0         v1 we1 a1       d1        rdy0 rdy1 wr
        tbl.push_back(mk(1, 0, 10'h005, 16'h0000, 1, 0, 10'h3FF, 16'h0000, 1, 1, 0));
        tbl.push_back(mk(1, 1, 10'h030, 16'hA001, 1, 1, 10'h031, 16'hB001, 1, 0, 1));
        tbl.push_back(mk(1, 1, 10'h030, 16'hA002, 1, 1, 10'h031, 16'hB002, 0, 1, 1));
        tbl.push_back(mk(1, 1, 10'h030, 16'hA003, 1, 1, 10'h031, 16'hB003, 1, 0, 1));
        tbl.push_back(mk(1, 0, 10'h030, 16'h0000, 1, 0, 10'h031, 16'h0000, 1, 1, 0));
        tbl.push_back(mk(1, 1, 10'h040, 16'hC000, 1, 1, 10'h041, 16'hD000, 0, 1, 1));
        tbl.push_back(mk(1, 1, 10'h010, 16'h1234, 1, 0, 10'h010, 16'h0000, 1, 1, 1));
        tbl.push_back(mk(0, 0, 10'h000, 16'h0000, 1, 0, 10'h010, 16'h0000, 1, 1, 0));
        tbl.push_back(mk(1, 1, 10'h020, 16'h1111, 0, 0, 10'h000, 16'h0000, 1, 1, 1));
        tbl.push_back(mk(1, 1, 10'h020, 16'h1111, 0, 0, 10'h000, 16'h0000, 1, 1, 1));
        tbl.push_back(mk(1, 1, 10'h020, 16'h2222, 1, 1, 10'h021, 16'h3333, 1, 0, 1));
        tbl.push_back(mk(1, 0, 10'h020, 16'h0000, 1, 1, 10'h022, 16'h4444, 1, 1, 1));
        tbl.push_back(mk(1, 0, 10'h022, 16'h0000, 1, 0, 10'h021, 16'h0000, 1, 1, 0));
        tbl.push_back(mk(1, 0, 10'h3FF, 16'h0000, 1, 0, 10'h005, 16'h0000, 1, 1, 0));
        tbl.push_back(mk(1, 0, 10'h040, 16'h0000, 1, 0, 10'h041, 16'h0000, 1, 1, 0));
        tbl.push_back(idle);

        foreach (tbl[i]) begin
            apply(tbl[i], i + 1);
        end

        // Read accepted, then reset on the very next cycle: the response must vanish.
        apply(mk(0, 0, 10'h000, 16'h0000, 1, 0, 10'h002, 16'h0000, 1, 1, 0), 100);
        rst_cycle(101);
        rst_cycle(102);
        reset = 1'b0;
        // Pointer was left at requester 1 above; after reset requester 0 must win again.
        apply(mk(1, 1, 10'h050, 16'h5050, 1, 1, 10'h051, 16'h5151, 1, 0, 1), 103);
        apply(mk(1, 0, 10'h050, 16'h0000, 1, 0, 10'h002, 16'h0000, 1, 1, 0), 104);
        apply(idle, 105);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
